// File: rtl/sequencer_pkg.sv
// ----------------------------------------------------------------------------
// sequencer_pkg
// Shared definitions for the timing sequencer slice.
//   STATES_DEFAULT : default number of timing states (T0..T15)
//   T0_ONEHOT      : one-hot value of state T0, sized by the user with a cast
//   clog2()        : ceiling log2, used to derive the count width from STATES
// ----------------------------------------------------------------------------
package sequencer_pkg;

    localparam int          STATES_DEFAULT = 16;
    localparam int unsigned T0_ONEHOT      = 1;

    // Ceiling log2 for n >= 2 (clog2(2) = 1, clog2(16) = 4, clog2(256) = 8).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/timing_sequencer_if.sv
// ----------------------------------------------------------------------------
// timing_sequencer_if
// Bundles the control inputs and timing outputs of timing_sequencer.
//   master : control-logic side; drives SC_CLR, INR, LD, LD_VAL, TC and
//            observes SC, T, WRAP, ERR
//   slave  : the sequencer itself
// Signalling: there is no valid/ready handshake. Every input is a level that
// is sampled on each rising clock edge; every output is a register that
// changes only on that edge (or on asynchronous reset).
// ----------------------------------------------------------------------------
interface timing_sequencer_if
    import sequencer_pkg::*;
#(
    parameter int STATES = STATES_DEFAULT,
    parameter int W      = clog2(STATES)
);

    logic              SC_CLR;
    logic              INR;
    logic              LD;
    logic [W-1:0]      LD_VAL;
    logic [W-1:0]      TC;
    logic [W-1:0]      SC;
    logic [STATES-1:0] T;
    logic              WRAP;
    logic              ERR;

    modport master (
        output SC_CLR, INR, LD, LD_VAL, TC,
        input  SC, T, WRAP, ERR
    );

    modport slave (
        input  SC_CLR, INR, LD, LD_VAL, TC,
        output SC, T, WRAP, ERR
    );

endinterface

// File: rtl/onehot_decoder.sv
// ----------------------------------------------------------------------------
// onehot_decoder
// Purely combinational index-to-one-hot decoder. The sequencer feeds it the
// next-state count so that T is registered on the same edge as SC.
//   idx    : in  clog2(N) bits, index to decode (0..N-1)
//   onehot : out N bits, bit idx set, all others clear
// ----------------------------------------------------------------------------
module onehot_decoder
    import sequencer_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [clog2(N)-1:0] idx,
    output logic [N-1:0]        onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// ----------------------------------------------------------------------------
// timing_sequencer
// Configurable-depth sequence counter with one-hot timing outputs for the
// basic-computer control unit.
//   CLK : system clock, rising edge
//   CLR : asynchronous active-high reset (SC=0, T=T0, WRAP=0, ERR=0)
//   bus : timing_sequencer_if.slave
//         SC_CLR  synchronous clear          INR  advance enable
//         LD      synchronous load of LD_VAL TC   terminal state
//         SC      registered count           T    registered one-hot of SC
//         WRAP    pulse in the cycle after a wrap
//         ERR     sticky flag for an out-of-range load
// Edge priority: CLR > SC_CLR > LD > INR > hold.
// ----------------------------------------------------------------------------
module timing_sequencer
    import sequencer_pkg::*;
#(
    parameter int STATES = STATES_DEFAULT
) (
    input logic               CLK,
    input logic               CLR,
    timing_sequencer_if.slave bus
);

    localparam int              W        = clog2(STATES);
    // One extra bit so STATES itself is representable (e.g. 256 with W=8).
    localparam logic [W:0]      STATES_X = (W+1)'(STATES);
    localparam logic [W-1:0]    LAST_IDX = W'(STATES - 1);
    localparam logic [W-1:0]    ONE      = W'(1);

    logic [W-1:0]      sc_q;
    logic [W-1:0]      sc_next;
    logic [W-1:0]      tc_eff;
    logic [STATES-1:0] t_q;
    logic [STATES-1:0] t_next;
    logic              wrap_q;
    logic              wrap_next;
    logic              err_q;
    logic              err_next;
    logic              ld_legal;

    // A terminal count beyond the last state behaves as the last state.
    always_comb begin
        tc_eff   = ({1'b0, bus.TC} >= STATES_X) ? LAST_IDX : bus.TC;
        ld_legal = ({1'b0, bus.LD_VAL} < STATES_X) && (bus.LD_VAL <= tc_eff);
    end

    // Next-state selection. An illegal load still wins over INR so the
    // count holds in that cycle; it only raises ERR.
    always_comb begin
        sc_next   = sc_q;
        wrap_next = 1'b0;
        err_next  = err_q;
        if (bus.SC_CLR) begin
            sc_next = '0;
        end else if (bus.LD) begin
            if (ld_legal) begin
                sc_next = bus.LD_VAL;
            end else begin
                err_next = 1'b1;
            end
        end else if (bus.INR) begin
            // ">=" rather than "==" so a TC lowered below the current count
            // at runtime still returns the sequence to T0 on the next advance.
            if (sc_q < tc_eff) begin
                sc_next = sc_q + ONE;
            end else begin
                sc_next   = '0;
                wrap_next = 1'b1;
            end
        end
    end

    // Decode the next count so T and SC are registered together and T never
    // lags SC by a cycle.
    onehot_decoder #(
        .N (STATES)
    ) u_decoder (
        .idx    (sc_next),
        .onehot (t_next)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sc_q   <= '0;
            t_q    <= STATES'(T0_ONEHOT);
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sc_q   <= sc_next;
            t_q    <= t_next;
            wrap_q <= wrap_next;
            err_q  <= err_next;
        end
    end

    assign bus.SC   = sc_q;
    assign bus.T    = t_q;
    assign bus.WRAP = wrap_q;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// ----------------------------------------------------------------------------
// tb_timing_sequencer
// Scoreboard bench for timing_sequencer. The main instance (STATES=16) is
// driven with directed and random stimulus; three extra instances
// (STATES=2, 8, 256) free-run for the parameter sweep. Drivers push the
// expected post-edge state, computed from the sequencing rules, into queues;
// a single monitor pops and compares after each rising edge, and also on
// request in the middle of a cycle for asynchronous-reset checks.
// ----------------------------------------------------------------------------
module tb_timing_sequencer;

    typedef struct {
        int sc;
        bit wrap;
        bit err;
    } mst_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    timing_sequencer_if #(.STATES(16)) bus ();

    timing_sequencer #(
        .STATES (16)
    ) dut (
        .CLK (clk),
        .CLR (rst),
        .bus (bus)
    );

    // ---------------- sweep DUTs ----------------
    logic         sw_inr = 1'b0;
    logic [8:0]   sw_sc   [3];
    logic [255:0] sw_t    [3];
    logic         sw_wrap [3];

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int S = (g == 0) ? 2 : (g == 1) ? 8 : 256;

        timing_sequencer_if #(.STATES(S)) sbus ();

        // TC = all ones = S-1 for these power-of-two depths.
        assign sbus.SC_CLR = 1'b0;
        assign sbus.LD     = 1'b0;
        assign sbus.LD_VAL = '0;
        assign sbus.TC     = '1;
        assign sbus.INR    = sw_inr;

        assign sw_sc[g]   = 9'(sbus.SC);
        assign sw_t[g]    = 256'(sbus.T);
        assign sw_wrap[g] = sbus.WRAP;

        timing_sequencer #(
            .STATES (S)
        ) dut_s (
            .CLK (clk),
            .CLR (rst),
            .bus (sbus)
        );
    end

    // ---------------- scoreboard state ----------------
    logic [21:0] exp_q [$];   // {err, wrap, t[15:0], sc[3:0]} after an edge
    logic [21:0] imm_q [$];   // same format, checked mid-cycle
    logic [11:0] sw_q  [$];   // {inst[1:0], sc[8:0], wrap}
    int          imm_cnt   = 0;
    bit          stim_done = 1'b0;
    int          n_checks  = 0;
    int          n_fails   = 0;
    mst_t        m;
    mst_t        sw_m [3];

    // Reference rules for one clock edge (CLR is handled by the caller).
    function automatic mst_t model_next(input mst_t s, input int states,
                                        input bit c, input bit inr, input bit ld,
                                        input int ldv, input int tcv);
        mst_t n;
        int   last;
        n      = s;
        n.wrap = 1'b0;
        last   = (tcv >= states) ? states - 1 : tcv;
        if (c) begin
            n.sc = 0;
        end else if (ld) begin
            if (ldv <= last && ldv < states) n.sc = ldv;
            else                             n.err = 1'b1;
        end else if (inr) begin
            if (s.sc < last) begin
                n.sc = s.sc + 1;
            end else begin
                n.sc   = 0;
                n.wrap = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [21:0] pack_main(input mst_t s);
        int t;
        t = 1 << s.sc;
        return {s.err, s.wrap, 16'(t), 4'(s.sc)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit c, input bit inr, input bit ld,
                         input int ldv, input int tcv);
        @(negedge clk);
        bus.SC_CLR = c;
        bus.INR    = inr;
        bus.LD     = ld;
        bus.LD_VAL = 4'(ldv);
        bus.TC     = 4'(tcv);
        m = model_next(m, 16, c, inr, ld, ldv, tcv);
        exp_q.push_back(pack_main(m));
    endtask

    task automatic set_idle();
        bus.SC_CLR = 1'b0;
        bus.INR    = 1'b0;
        bus.LD     = 1'b0;
        bus.LD_VAL = '0;
    endtask

    // Assert CLR between edges, check the outputs before the next edge,
    // hold for some edges, then release on a falling edge.
    task automatic async_reset(input int hold_edges);
        @(negedge clk);
        #2;
        rst = 1'b1;
        set_idle();
        m = '{sc: 0, wrap: 1'b0, err: 1'b0};
        #1;
        imm_q.push_back(pack_main(m));
        imm_cnt = imm_cnt + 1;
        repeat (hold_edges) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_main(input string tag, input logic [21:0] e);
        cmp({tag, "_sc"},   256'(bus.SC),   256'(e[3:0]));
        cmp({tag, "_t"},    256'(bus.T),    256'(e[19:4]));
        cmp({tag, "_wrap"}, 256'(bus.WRAP), 256'(e[20]));
        cmp({tag, "_err"},  256'(bus.ERR),  256'(e[21]));
    endtask

    initial begin : monitor
        int           seen;
        int           drain;
        int           gi;
        logic [21:0]  e;
        logic [11:0]  se;
        logic [255:0] one256;
        logic [255:0] exp_t;
        seen   = 0;
        drain  = 0;
        one256 = 256'(1);
        forever begin
            @(posedge clk or imm_cnt);
            if (imm_cnt != seen) begin
                seen = imm_cnt;
                while (imm_q.size() > 0) begin
                    e = imm_q.pop_front();
                    check_main("async", e);
                end
            end else begin
                #1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_main("edge", e);
                end
                while (sw_q.size() > 0) begin
                    se    = sw_q.pop_front();
                    gi    = int'(se[11:10]);
                    exp_t = one256 << se[9:1];
                    cmp("sweep_sc",     256'(sw_sc[gi]),   256'(se[9:1]));
                    cmp("sweep_t",      sw_t[gi],          exp_t);
                    cmp("sweep_onehot", 256'($countones(sw_t[gi])), 256'(1));
                    cmp("sweep_wrap",   256'(sw_wrap[gi]), 256'(se[0]));
                end
                if (stim_done) begin
                    if (exp_q.size() == 0 && sw_q.size() == 0 && imm_q.size() == 0) begin
                        $display("End of test - %0d assertions evaluated, %0d failures",
                                 n_checks, n_fails);
                        $finish;
                    end
                    drain = drain + 1;
                    if (drain > 5) begin
                        n_checks = n_checks + 1;
                        n_fails  = n_fails + 1;
                        $display("FAIL drain: %0d expectations left, required 0",
                                 exp_q.size() + sw_q.size() + imm_q.size());
                        $display("End of test - %0d assertions evaluated, %0d failures",
                                 n_checks, n_fails);
                        $finish;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int r;
        int tcv;
        int ldv;
        bit c;
        bit ld;
        bit inr;

        set_idle();
        bus.TC = 4'd15;
        m = '{sc: 0, wrap: 1'b0, err: 1'b0};
        for (int g = 0; g < 3; g++) sw_m[g] = '{sc: 0, wrap: 1'b0, err: 1'b0};

        // Reset state, checked while CLR is held.
        #1 rst = 1'b1;
        #1;
        imm_q.push_back(pack_main(m));
        imm_cnt = imm_cnt + 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free run through a full cycle and past the wrap.
        for (int i = 0; i < 18; i++) drive(0, 1, 0, 0, 15);

        // Short instruction cycle: TC=3, pulsed INR, clear at SC=2 with INR.
        drive(1, 0, 0, 0, 3);
        drive(0, 1, 0, 0, 3);
        drive(0, 0, 0, 0, 3);
        drive(0, 1, 0, 0, 3);
        drive(1, 1, 0, 0, 3);
        drive(0, 0, 0, 0, 3);
        // Clear against a wrap condition: clear wins, no WRAP.
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 3);
        drive(1, 1, 0, 0, 3);
        drive(0, 0, 0, 0, 3);

        // Loads: legal, illegal (sticky ERR), clear keeps ERR, load beats INR.
        drive(0, 0, 1, 5, 7);
        drive(0, 1, 1, 9, 7);
        drive(0, 0, 0, 0, 7);
        drive(1, 0, 0, 0, 7);
        drive(0, 1, 1, 7, 7);
        drive(0, 1, 0, 0, 7);
        drive(0, 0, 1, 0, 7);
        async_reset(1);
        drive(0, 0, 0, 0, 7);

        // Runtime TC shrink below the current count.
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0, 15);
        drive(0, 1, 0, 0, 4);
        drive(0, 1, 0, 0, 4);
        drive(0, 0, 0, 0, 4);

        // Async reset mid-count at SC=6, then hold with INR low.
        drive(1, 0, 0, 0, 15);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 15);
        async_reset(2);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 15);

        // Async reset while WRAP is high cancels the pulse.
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 2);
        async_reset(1);
        drive(0, 0, 0, 0, 2);

        // Back-to-back wraps with TC=0.
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Random mix.
        tcv = 15;
        for (int i = 0; i < 400; i++) begin
            r   = $urandom_range(0, 99);
            c   = (r < 6);
            ld  = (r >= 6 && r < 18);
            inr = ($urandom_range(0, 3) != 0);
            ldv = $urandom_range(0, 15);
            if ($urandom_range(0, 11) == 0) tcv = $urandom_range(0, 15);
            if ($urandom_range(0, 149) == 0) async_reset(1);
            drive(c, inr, ld, ldv, tcv);
        end
        drive(0, 0, 0, 0, 15);

        // Parameter sweep: free-run the 2/8/256-state instances over two
        // full cycles of the deepest one.
        for (int cyc = 0; cyc < 2 * 256 + 4; cyc++) begin
            @(negedge clk);
            sw_inr = 1'b1;
            for (int g = 0; g < 3; g++) begin
                sw_m[g] = model_next(sw_m[g], (g == 0) ? 2 : (g == 1) ? 8 : 256,
                                     1'b0, 1'b1, 1'b0, 0,
                                     ((g == 0) ? 2 : (g == 1) ? 8 : 256) - 1);
                sw_q.push_back({2'(g), 9'(sw_m[g].sc), sw_m[g].wrap});
            end
        end
        @(negedge clk);
        sw_inr    = 1'b0;
        stim_done = 1'b1;
    end

endmodule
